// File: rtl/frame_serializer.sv
// frame_serializer: captures a din_valid burst into an NUM_CHANNELS-deep
// buffer, then streams a fixed-length frame on a valid/ready port, padding
// unfilled channels with PAD_VALUE. Samples arriving while a frame is being
// emitted are dropped, pulsed on overrun and counted in drop_count.
//
// Optional build macro SER_CHECKSUM_EN: appends one XOR checksum word to
// every frame (dout_last moves to that word).
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | waiting for din_valid to start a burst
// S_CAPTURE | storing burst samples into the buffer
// S_EMIT    | presenting frame words on dout, advancing on dout_ready
module frame_serializer #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    NUM_CHANNELS = 8,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE    = '0,
    parameter int                    CNT_WIDTH    = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [DATA_WIDTH-1:0]                 din,
    input  logic                                  din_valid,
    output logic [DATA_WIDTH-1:0]                 dout,
    output logic                                  dout_valid,
    input  logic                                  dout_ready,
    output logic                                  dout_first,
    output logic                                  dout_last,
    output logic [$clog2(NUM_CHANNELS+1)-1:0]     frame_len,
    output logic                                  overrun,
    output logic [CNT_WIDTH-1:0]                  drop_count
);

    localparam int LEN_W  = $clog2(NUM_CHANNELS + 1);
    localparam int BUF_AW = $clog2(NUM_CHANNELS);
    localparam logic [BUF_AW-1:0] TOP_WR = BUF_AW'(NUM_CHANNELS - 1);
`ifdef SER_CHECKSUM_EN
    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(NUM_CHANNELS);
`else
    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(NUM_CHANNELS - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_EMIT
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] buf_q [NUM_CHANNELS];
    logic [BUF_AW-1:0]     wr_idx_q;
    logic [LEN_W-1:0]      rd_idx_q;
    logic [LEN_W-1:0]      rd_idx_d;
    logic [LEN_W-1:0]      frame_len_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] word_d;
    logic                  dout_valid_q;
    logic                  first_q;
    logic                  last_q;
    logic                  overrun_q;
    logic [CNT_WIDTH-1:0]  drop_cnt_q;
    logic [CNT_WIDTH-1:0]  drop_cnt_d;
`ifdef SER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q;
`endif

    // Next read index, the word it selects, and the saturating drop count.
    always_comb begin
        rd_idx_d = rd_idx_q + LEN_W'(1);
        word_d   = PAD_VALUE;
        if (rd_idx_d < frame_len_q) begin
            word_d = buf_q[rd_idx_d[BUF_AW-1:0]];
        end
`ifdef SER_CHECKSUM_EN
        if (rd_idx_d == LEN_W'(NUM_CHANNELS)) begin
            // checksum covers every word already emitted, pads included
            word_d = csum_q ^ dout_q;
        end
`endif
        drop_cnt_d = (drop_cnt_q == '1) ? drop_cnt_q : drop_cnt_q + CNT_WIDTH'(1);
    end

    // Capture / emit state machine with registered stream outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            frame_len_q  <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            overrun_q    <= 1'b0;
            drop_cnt_q   <= '0;
`ifdef SER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            overrun_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (din_valid) begin
                        buf_q[0] <= din;
                        wr_idx_q <= BUF_AW'(1);
                        state_q  <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (din_valid && (wr_idx_q != TOP_WR)) begin
                        buf_q[wr_idx_q] <= din;
                        wr_idx_q        <= wr_idx_q + BUF_AW'(1);
                    end else begin
                        // close the frame: either the buffer just filled or the burst ended
                        if (din_valid) begin
                            buf_q[wr_idx_q] <= din;
                            frame_len_q     <= LEN_W'(NUM_CHANNELS);
                        end else begin
                            frame_len_q     <= LEN_W'(wr_idx_q);
                        end
                        // buf_q[0] is always a real sample, so word 0 needs no pad check
                        dout_q       <= buf_q[0];
                        dout_valid_q <= 1'b1;
                        first_q      <= 1'b1;
                        last_q       <= 1'b0;
                        rd_idx_q     <= '0;
                        wr_idx_q     <= '0;
`ifdef SER_CHECKSUM_EN
                        csum_q       <= '0;
`endif
                        state_q      <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (din_valid) begin
                        overrun_q  <= 1'b1;
                        drop_cnt_q <= drop_cnt_d;
                    end
                    if (dout_ready) begin
`ifdef SER_CHECKSUM_EN
                        csum_q <= csum_q ^ dout_q;
`endif
                        if (rd_idx_q == LAST_IDX) begin
                            dout_valid_q <= 1'b0;
                            first_q      <= 1'b0;
                            last_q       <= 1'b0;
                            rd_idx_q     <= '0;
                            state_q      <= S_IDLE;
                        end else begin
                            rd_idx_q <= rd_idx_d;
                            dout_q   <= word_d;
                            first_q  <= 1'b0;
                            last_q   <= (rd_idx_d == LAST_IDX);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_first = first_q;
    assign dout_last  = last_q;
    assign frame_len  = frame_len_q;
    assign overrun    = overrun_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer: a table of bursts (length, first
// value, ready pattern, expected frame_len) with a cycle-by-cycle reference
// of the frame, plus hand sequences for a drop on the final transfer edge
// and a reset in the middle of a frame. A narrow drop counter is used so
// saturation is reached quickly.
module tb_frame_serializer;

    localparam int NC = 8;
    localparam int CW = 3;
`ifdef SER_CHECKSUM_EN
    localparam int WORDS = NC + 1;
`else
    localparam int WORDS = NC;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    din;
    logic          din_valid;
    logic [7:0]    dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_first;
    logic          dout_last;
    logic [3:0]    frame_len;
    logic          overrun;
    logic [CW-1:0] drop_count;

    frame_serializer #(
        .DATA_WIDTH   (8),
        .NUM_CHANNELS (NC),
        .PAD_VALUE    (8'h00),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_first (dout_first),
        .dout_last  (dout_last),
        .frame_len  (frame_len),
        .overrun    (overrun),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [CW-1:0] exp_drop_cnt;

    typedef struct {
        int         n;
        logic [7:0] start;
        int         mode;
        int         exp_len;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ready_of(input int mode, input int c, input int fv);
        case (mode)
            1:       return (c % 3) == 0;
            2:       return !((c >= fv + 2) && (c < fv + 7));
            default: return 1'b1;
        endcase
    endfunction

    function automatic void bump_drop();
        if (exp_drop_cnt != '1) exp_drop_cnt = exp_drop_cnt + CW'(1);
    endfunction

    // Drive one burst of n consecutive samples and check every output each cycle.
    task automatic run_frame(input int n, input logic [7:0] start, input int mode, input int exp_len);
        int         fv;
        int         w;
        int         tail;
        logic       drop_pend;
        logic       ev;
        logic [7:0] exp_word;
        logic [7:0] cs;
        fv        = (n < NC) ? n + 1 : NC;
        w         = 0;
        tail      = 0;
        drop_pend = 1'b0;
        cs        = 8'h00;
        exp_word  = 8'h00;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            ev = (c >= fv) && (w < WORDS);
            chk("dout_valid", 32'(dout_valid), 32'(ev));
            chk("overrun", 32'(overrun), 32'(drop_pend));
            chk("drop_count", 32'(drop_count), 32'(exp_drop_cnt));
            if (ev) begin
                if (w < NC) exp_word = (w < n) ? start + 8'(w) : 8'h00;
                else        exp_word = cs;
                chk("dout", 32'(dout), 32'(exp_word));
                chk("dout_first", 32'(dout_first), 32'(w == 0));
                chk("dout_last", 32'(dout_last), 32'(w == WORDS - 1));
                chk("frame_len", 32'(frame_len), 32'(exp_len));
            end
            din_valid  = (c < n);
            din        = (c < n) ? start + 8'(c) : 8'h00;
            dout_ready = ready_of(mode, c, fv);
            drop_pend  = din_valid && ev;
            if (drop_pend) bump_drop();
            if (ev && dout_ready) begin
                if (w < NC) cs = cs ^ exp_word;
                w++;
            end
            if (w == WORDS && c >= n) tail++;
            if (tail == 3) break;
        end
        chk("words_seen", 32'(w), 32'(WORDS));
        chk("frame_len_hold", 32'(frame_len), 32'(exp_len));
    endtask

    initial begin
        vecs[0] = '{n: 4,  start: 8'hA1, mode: 0, exp_len: 4};
        vecs[1] = '{n: 2,  start: 8'hE5, mode: 0, exp_len: 2};
        vecs[2] = '{n: 10, start: 8'h01, mode: 0, exp_len: 8};
        vecs[3] = '{n: 4,  start: 8'h11, mode: 1, exp_len: 4};
        vecs[4] = '{n: 4,  start: 8'h11, mode: 2, exp_len: 4};
        vecs[5] = '{n: 8,  start: 8'h40, mode: 1, exp_len: 8};
        vecs[6] = '{n: 1,  start: 8'h77, mode: 0, exp_len: 1};
        vecs[7] = '{n: 16, start: 8'h60, mode: 0, exp_len: 8};

        rst          = 1'b0;
        din          = 8'h00;
        din_valid    = 1'b0;
        dout_ready   = 1'b0;
        exp_drop_cnt = '0;
        repeat (2) @(negedge clk);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_dout_valid", 32'(dout_valid), 32'h0);
        chk("rst_first", 32'(dout_first), 32'h0);
        chk("rst_last", 32'(dout_last), 32'h0);
        chk("rst_frame_len", 32'(frame_len), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_drop_count", 32'(drop_count), 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].n, vecs[i].start, vecs[i].mode, vecs[i].exp_len);
        end

        // Sample arriving on the edge of the final transfer is dropped, not captured.
        for (int c = 0; c <= 5 + WORDS; c++) begin
            @(negedge clk);
            if (c == 3 + WORDS) begin
                chk("pre_drop_valid", 32'(dout_valid), 32'h1);
                chk("pre_drop_last", 32'(dout_last), 32'h1);
            end
            if (c == 4 + WORDS) begin
                chk("last_edge_valid", 32'(dout_valid), 32'h0);
                chk("last_edge_overrun", 32'(overrun), 32'h1);
                chk("last_edge_drop_count", 32'(drop_count), 32'(exp_drop_cnt));
            end
            if (c == 5 + WORDS) begin
                chk("last_edge_overrun_clear", 32'(overrun), 32'h0);
                chk("last_edge_still_idle", 32'(dout_valid), 32'h0);
            end
            din_valid  = (c < 3) || (c == 3 + WORDS);
            din        = din_valid ? 8'h50 + 8'(c) : 8'h00;
            dout_ready = 1'b1;
            if (c == 3 + WORDS) bump_drop();
        end

        // Reset while the third word of a frame is presented.
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c == 7) begin
                chk("pre_rst_dout", 32'(dout), 32'h33);
                rst = 1'b0;
            end
            if (c == 8) begin
                chk("mid_rst_valid", 32'(dout_valid), 32'h0);
                chk("mid_rst_drop_count", 32'(drop_count), 32'h0);
                chk("mid_rst_frame_len", 32'(frame_len), 32'h0);
                chk("mid_rst_first", 32'(dout_first), 32'h0);
                chk("mid_rst_overrun", 32'(overrun), 32'h0);
                rst          = 1'b1;
                exp_drop_cnt = '0;
            end
            din_valid  = (c < 4);
            din        = (c < 4) ? 8'h31 + 8'(c) : 8'h00;
            dout_ready = 1'b1;
        end
        run_frame(2, 8'h21, 0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_serializer.md
Name: frame_serializer

Overview:
Collects a burst of DATA_WIDTH-bit samples (marked by din_valid) into an NUM_CHANNELS-deep frame buffer. It then emits a fixed-length frame of NUM_CHANNELS words on a valid/ready output stream, padding short bursts with PAD_VALUE. It generalises the single-width channel serializer with:
- width, depth and pad parameters
- output backpressure
- first/last framing and a frame-length report
- overrun accounting

It sits between a per-channel sample source and downstream packetising logic.

Parameters:
DATA_WIDTH, 8, sample and output word width in bits
NUM_CHANNELS, 8, words per output frame; must be >= 2
PAD_VALUE, 0, word emitted for channels not filled by the burst (DATA_WIDTH bits)
CNT_WIDTH, 8, width of the saturating drop counter

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-low reset (rst=0 resets on the clock edge)
din  in  DATA_WIDTH  input sample
din_valid  in  1  sample on din is valid this cycle; high run = one burst
dout  out  DATA_WIDTH  output word
dout_valid  out  1  dout holds a frame word
dout_ready  in  1  downstream accepts; transfer = dout_valid & dout_ready at edge
dout_first  out  1  high with the first word of a frame
dout_last  out  1  high with the final word of a frame
frame_len  out  clog2(NUM_CHANNELS+1)  number of real (non-pad) samples in the frame being emitted
overrun  out  1  one-cycle pulse per dropped sample
drop_count  out  CNT_WIDTH  saturating count of dropped samples since reset

Behaviour:
- Reset values (rst=0 at edge): state IDLE, dout=0, dout_valid=0, dout_first=0, dout_last=0, frame_len=0, overrun=0, drop_count=0, write index=0, read index=0. Reset overrides everything, including a frame mid-emit or mid-capture; the buffer contents become don't-care.
- IDLE: on an edge with din_valid=1, store din at buffer[0], set write index to 1, go to CAPTURE. If NUM_CHANNELS were 1 this would close immediately (excluded by the parameter rule).
- CAPTURE:
  - Edge with din_valid=1: store din at buffer[write index] and increment the index.
  - If that store fills index NUM_CHANNELS-1, close the frame on that edge.
  - Edge with din_valid=0: close the frame.
  - Closing latches frame_len = words stored and goes to EMIT.
- EMIT:
  - dout_valid=1 from the cycle after closure.
  - dout = buffer[read index] if read index < frame_len, else PAD_VALUE.
  - dout_first=1 when read index=0; dout_last=1 when read index=NUM_CHANNELS-1.
  - On each transfer, read index increments. On the transfer of the last word, go to IDLE: dout_valid=0 next cycle and the indices clear.
- Latency: the first word is presented 1 cycle after the closing edge. With dout_ready held at 1, a frame occupies exactly NUM_CHANNELS consecutive cycles.
- Backpressure: while dout_valid=1 and dout_ready=0, dout, dout_first, dout_last and frame_len hold stable. dout_valid never drops mid-frame.
- Drop rule: din_valid=1 on any edge in EMIT, including the edge of the last transfer, drops that sample. It pulses overrun on the next cycle and increments drop_count, which saturates at all-ones.
  - A burst longer than NUM_CHANNELS therefore has its excess samples dropped.
  - A new burst is accepted only when din_valid=1 while in IDLE.
- frame_len holds its value after the frame until the next closure.

Optional Feature:
Macro SER_CHECKSUM_EN.
- Defined: each frame carries NUM_CHANNELS+1 words. The extra final word is the XOR of all preceding NUM_CHANNELS emitted words, including pads. dout_last moves to the checksum word; dout_first is unchanged.
- Undefined: no checksum logic; frames are exactly NUM_CHANNELS words.

Test Plan:
1. Defaults, dout_ready=1; burst A1,B2,C3,D4, then din_valid=0 -> frame A1,B2,C3,D4,00,00,00,00; dout_first on A1; dout_last on the 8th word; frame_len=4; first word appears 1 cycle after the valid-low edge.
2. Burst E5,F6 -> frame E5,F6 then six 00; frame_len=2; overrun never pulses.
3. Burst of 10 words 01..0A -> frame 01..08, frame_len=8; 09 and 0A dropped; overrun pulses twice; drop_count=2.
4. Burst 11..14 with dout_ready toggling 1,0,0,1,...; also hold dout_ready=0 for 5 cycles mid-frame -> dout stable while stalled; frame 11,12,13,14,00,00,00,00 intact; no duplicated or skipped words.
5. rst=0 for one edge during the 3rd word of a frame -> next cycle dout_valid=0, drop_count=0, state IDLE; a following burst 21,22 yields a correct frame with frame_len=2.
6. With SER_CHECKSUM_EN, burst A1,B2,C3,D4 -> 9 words ending in checksum 04 (A1^B2^C3^D4^00...); dout_last only on the checksum word.
